// File: rtl/ff_stuff_ctrl_pkg.sv
// ============================================================================
// Module  : jpeg_ff_pkg
// Brief   : Entry field map, FSM state type and EOI constants for ff_stuff_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jpeg_ff_pkg;

    localparam int ENTRY_W           = 91;
    localparam int ENTRY_PAYLOAD_MSB = 90;
    localparam int ENTRY_PAYLOAD_LSB = 27;
    localparam int ENTRY_COUNT_MSB   = 26;
    localparam int ENTRY_COUNT_LSB   = 23;
    localparam int ENTRY_LAST_BIT    = 22;

    localparam logic [7:0] JPEG_EOI_HI = 8'hFF;
    localparam logic [7:0] JPEG_EOI_LO = 8'hD9;

    localparam logic [3:0] MAX_ENTRY_BYTES = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_EMIT   = 3'd2,
        ST_STUFF  = 3'd3,
`ifdef FF_EOI_INSERT_EN
        ST_EOI_FF = 3'd4,
        ST_EOI_D9 = 3'd5,
`endif
        ST_DONE   = 3'd6
    } ff_stuff_state_t;

    // The count field can encode up to 15 but an entry never holds more than 8 bytes.
    function automatic logic [3:0] clamp_count(input logic [3:0] cnt);
        return (cnt > MAX_ENTRY_BYTES) ? MAX_ENTRY_BYTES : cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ff_stuff_ctrl_if.sv
// ============================================================================
// Module  : ff_stuff_ctrl_if
// Brief   : FIFO read side and byte stream bundle of the FF stuffing controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ff_stuff_ctrl_if
    import jpeg_ff_pkg::*;
#(
    parameter int STUFF_CNT_W = 16
) ();

    logic                   fifo_read_req;
    logic [ENTRY_W-1:0]     fifo_read_data;
    logic                   fifo_rdata_valid;
    logic                   fifo_empty;
    logic [7:0]             byte_out;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   stream_done;
    logic [STUFF_CNT_W-1:0] stuff_count;

    modport master (
        output fifo_read_req,
        input  fifo_read_data,
        input  fifo_rdata_valid,
        input  fifo_empty,
        output byte_out,
        output byte_valid,
        input  byte_ready,
        output stream_done,
        output stuff_count
    );

    modport slave (
        input  fifo_read_req,
        output fifo_read_data,
        output fifo_rdata_valid,
        output fifo_empty,
        input  byte_out,
        input  byte_valid,
        output byte_ready,
        input  stream_done,
        input  stuff_count
    );

endinterface

`default_nettype wire

// File: rtl/ff_stuff_ctrl.sv
// ============================================================================
// Module  : ff_stuff_ctrl
// Brief   : Reads FIFO entries, unpacks bytes MSB first, stuffs 0x00 after 0xFF.
//           Define FF_EOI_INSERT_EN to append 0xFF 0xD9 after a last entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ff_stuff_ctrl
    import jpeg_ff_pkg::*;
#(
    parameter int STUFF_CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ff_stuff_ctrl_if.master   bus
);

    localparam logic [STUFF_CNT_W-1:0] C_STUFF_MAX = '1;

    ff_stuff_state_t        r_state;
    ff_stuff_state_t        w_state_nxt;
    logic [63:0]            r_payload;
    logic [3:0]             r_count;
    logic                   r_last;
    logic [3:0]             r_idx;
    logic [STUFF_CNT_W-1:0] r_stuff_count;

    logic [2:0]             w_sel;
    logic [7:0]             w_emit_byte;
    logic                   w_idx_done;
    logic [3:0]             w_cap_count;
    logic                   w_cap_last;
    ff_stuff_state_t        w_end_state;
    ff_stuff_state_t        w_cap_end_state;
    logic                   w_req;
    logic                   w_valid;
    logic [7:0]             w_byte;
    logic                   w_done;
    logic                   w_xfer;
    logic                   w_adv;
    logic                   w_unused_ignored;

    assign w_sel       = 3'd7 - r_idx[2:0];
    assign w_emit_byte = r_payload[{w_sel, 3'b000} +: 8];
    assign w_idx_done  = ((r_idx + 4'd1) == r_count);
    assign w_cap_count = clamp_count(bus.fifo_read_data[ENTRY_COUNT_MSB:ENTRY_COUNT_LSB]);
    assign w_cap_last  = bus.fifo_read_data[ENTRY_LAST_BIT];
    assign w_unused_ignored = ^bus.fifo_read_data[ENTRY_LAST_BIT-1:0];

`ifdef FF_EOI_INSERT_EN
    assign w_end_state     = r_last     ? ST_EOI_FF : ST_IDLE;
    assign w_cap_end_state = w_cap_last ? ST_EOI_FF : ST_IDLE;
`else
    assign w_end_state     = r_last     ? ST_DONE : ST_IDLE;
    assign w_cap_end_state = w_cap_last ? ST_DONE : ST_IDLE;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        w_byte      = 8'h00;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = !bus.fifo_empty;
                if (!bus.fifo_empty) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.fifo_rdata_valid) begin
                    w_state_nxt = (w_cap_count == 4'd0) ? w_cap_end_state : ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_valid = 1'b1;
                w_byte  = w_emit_byte;
                if (bus.byte_ready) begin
                    if (w_emit_byte == 8'hFF) begin
                        w_state_nxt = ST_STUFF;
                    end else if (w_idx_done) begin
                        w_state_nxt = w_end_state;
                    end
                end
            end
            ST_STUFF: begin
                w_valid = 1'b1;
                if (bus.byte_ready) begin
                    w_state_nxt = w_idx_done ? w_end_state : ST_EMIT;
                end
            end
`ifdef FF_EOI_INSERT_EN
            ST_EOI_FF: begin
                w_valid = 1'b1;
                w_byte  = JPEG_EOI_HI;
                if (bus.byte_ready) begin
                    w_state_nxt = ST_EOI_D9;
                end
            end
            ST_EOI_D9: begin
                w_valid = 1'b1;
                w_byte  = JPEG_EOI_LO;
                if (bus.byte_ready) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_xfer = w_valid & bus.byte_ready;
    // Index moves on after a plain byte or after the 0x00 that follows a 0xFF.
    assign w_adv  = w_xfer & (((r_state == ST_EMIT) & (w_emit_byte != 8'hFF)) |
                              (r_state == ST_STUFF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_payload     <= 64'd0;
            r_count       <= 4'd0;
            r_last        <= 1'b0;
            r_idx         <= 4'd0;
            r_stuff_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_WAIT) && bus.fifo_rdata_valid) begin
                r_payload <= bus.fifo_read_data[ENTRY_PAYLOAD_MSB:ENTRY_PAYLOAD_LSB];
                r_count   <= w_cap_count;
                r_last    <= w_cap_last;
                r_idx     <= 4'd0;
            end else if (w_adv && !w_idx_done) begin
                r_idx <= r_idx + 4'd1;
            end
            if ((r_state == ST_STUFF) && w_xfer && (r_stuff_count != C_STUFF_MAX)) begin
                r_stuff_count <= r_stuff_count + 1'b1;
            end
        end
    end

    // Gate with rst_n so no read is requested while the block is held in reset.
    assign bus.fifo_read_req = w_req & rst_n;
    assign bus.byte_valid    = w_valid;
    assign bus.byte_out      = w_byte;
    assign bus.stream_done   = w_done;
    assign bus.stuff_count   = r_stuff_count;

endmodule

`default_nettype wire
